// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file behind a 7-bit device address.
// Supports pointer write, burst write and burst read with pointer wrap.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_o,
  output logic                     busy,
  output logic                     wr_valid,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic [6:0]    r_shift, w_shift_nxt;
  logic [6:0]    r_tx, w_tx_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_mack, w_mack_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_sda_o, w_sda_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_wr_valid, w_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_regs [DEPTH];

  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_in_byte, w_last;
  logic [7:0]    w_byte, w_rd_byte;

  // Bus inputs idle high, so the synchronizers reset to 1 to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_rd_byte  = r_regs[r_ptr];
  assign w_in_byte  = (r_state == ST_ADDR) || (r_state == ST_PTR) ||
                      (r_state == ST_WDATA) || (r_state == ST_RDATA);
  assign w_last     = w_scl_rise && (r_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Ack states use r_cnt as a phase flag: 0 = before the ack slot, 1 = inside it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_rw_nxt    = r_rw;
    w_mack_nxt  = r_mack;
    w_ptr_nxt   = r_ptr;
    w_sda_nxt   = r_sda_o;
    w_busy_nxt  = r_busy;
    w_wr_en     = 1'b0;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
      w_sda_nxt   = 1'b1;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = 3'd0;
      w_sda_nxt   = 1'b1;
    end else begin
      if (w_scl_rise && w_in_byte) begin
        w_shift_nxt = w_byte[6:0];
        w_cnt_nxt   = r_cnt + 3'd1;
      end
      case (r_state)
        ST_ADDR: if (w_last) begin
          if (w_byte[7:1] == DEV_ADDR) begin
            w_state_nxt = ST_ADDR_ACK;
            w_busy_nxt  = 1'b1;
            w_rw_nxt    = w_byte[0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
        ST_PTR: if (w_last) begin
          w_state_nxt = ST_PTR_ACK;
          w_ptr_nxt   = w_byte[AW-1:0];
        end
        ST_WDATA: if (w_last) begin
          w_state_nxt = ST_WDATA_ACK;
          w_wr_en     = 1'b1;
          w_ptr_nxt   = r_ptr + AW'(1);
        end
        ST_RDATA: begin
          if (w_last) begin
            w_state_nxt = ST_RDATA_ACK;
            w_ptr_nxt   = r_ptr + AW'(1);
          end else if (w_scl_fall) begin
            w_tx_nxt  = {r_tx[5:0], 1'b0};
            w_sda_nxt = r_tx[6];
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
          if (r_cnt == 3'd0) begin
            w_sda_nxt = 1'b0;
            w_cnt_nxt = 3'd1;
          end else begin
            w_cnt_nxt = 3'd0;
            w_sda_nxt = 1'b1;
            if (r_state == ST_ADDR_ACK && r_rw) begin
              w_state_nxt = ST_RDATA;
              w_tx_nxt    = w_rd_byte[6:0];
              w_sda_nxt   = w_rd_byte[7];
            end else if (r_state == ST_ADDR_ACK) begin
              w_state_nxt = ST_PTR;
            end else begin
              w_state_nxt = ST_WDATA;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) w_mack_nxt = r_sda_s2;
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_nxt = 1'b1;
              w_cnt_nxt = 3'd1;
            end else begin
              w_cnt_nxt = 3'd0;
              if (!r_mack) begin
                w_state_nxt = ST_RDATA;
                w_tx_nxt    = w_rd_byte[6:0];
                w_sda_nxt   = w_rd_byte[7];
              end else begin
                w_state_nxt = ST_WAIT_STOP;
                w_sda_nxt   = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b1;
      r_ptr      <= '0;
      r_sda_o    <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sda_o    <= w_sda_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_en;
      if (w_wr_en) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_addr     <= r_ptr;
        r_wr_data     <= w_byte;
      end
    end
  end

  assign sda_o    = r_sda_o;
  assign busy     = r_busy;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the bus while
// scoreboard monitors compare ACKs, read bytes and write strobes.
module tb_i2c_target_regs;
  localparam int T  = 40;
  localparam int AW = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          sda_o, busy, wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          w_sda_bus;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_wr      = 0;
  int sda_viol  = 0;
  int busy_viol = 0;
  bit watch_rel  = 1'b0;
  bit watch_busy = 1'b0;

  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  logic [7:0]  obs_q[$];
  logic [31:0] exp_wr_q[$];

  assign w_sda_bus = m_sda & sda_o;

  i2c_target_regs #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(w_sda_bus), .sda_o(sda_o),
    .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for ACK bits and read bytes seen by the master.
  initial begin : sb_monitor
    logic [7:0] o;
    forever begin
      @(negedge clk);
      while (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        if (exp_val_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_obs: got 0x%0h, expected nothing", o);
        end else begin
          check(exp_name_q.pop_front(), 32'(o), exp_val_q.pop_front());
        end
      end
    end
  end

  // Scoreboard for register write strobes.
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      n_wr++;
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wr: got addr %0d data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        check("wr_addr_data", 32'({wr_addr, wr_data}), exp_wr_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (watch_rel && sda_o !== 1'b1) sda_viol++;
    if (watch_busy && busy !== 1'b0) busy_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic i2c_start();
    m_sda = 1'b1; #(T); m_scl = 1'b1; #(T); m_sda = 1'b0; #(T); m_scl = 1'b0; #(T);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(T); m_scl = 1'b1; #(T); m_sda = 1'b1; #(T);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; #(T); m_scl = 1'b1; #(2*T); m_scl = 1'b0; #(T);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #(T); m_scl = 1'b1; #(T); b = w_sda_bus; #(T); m_scl = 1'b0; #(T);
  endtask

  task automatic send(input logic [7:0] d, input logic ack_exp, input string nm);
    logic a;
    exp_name_q.push_back(nm);
    exp_val_q.push_back(32'(ack_exp));
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    obs_q.push_back({7'b0, a});
  endtask

  task automatic recv(input logic [7:0] exp, input logic mack, input string nm);
    logic [7:0] d;
    logic       b;
    exp_name_q.push_back(nm);
    exp_val_q.push_back(32'(exp));
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    obs_q.push_back(d);
    write_bit(mack);
  endtask

  initial begin : stim
    logic [3:0] nib;
    logic       b;
    int         wr_before;
    repeat (3) @(negedge clk);
    check("rst_sda_o", 32'(sda_o), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    rst = 1'b0;
    #(4*T);

    // Single write: reg 3 <= 0x5A
    i2c_start();
    send(8'hA0, 1'b0, "w1_addr_ack");
    send(8'h03, 1'b0, "w1_ptr_ack");
    check("w1_busy_high", 32'(busy), 32'h1);
    exp_wr_q.push_back(32'({4'h3, 8'h5A}));
    send(8'h5A, 1'b0, "w1_data_ack");
    i2c_stop();
    #(T);
    check("w1_busy_after_stop", 32'(busy), 32'h0);

    // Burst write with wrap: reg 15 <= 0x11, reg 0 <= 0x22
    i2c_start();
    send(8'hA0, 1'b0, "w2_addr_ack");
    send(8'h0F, 1'b0, "w2_ptr_ack");
    exp_wr_q.push_back(32'({4'hF, 8'h11}));
    send(8'h11, 1'b0, "w2_d0_ack");
    exp_wr_q.push_back(32'({4'h0, 8'h22}));
    send(8'h22, 1'b0, "w2_d1_ack");
    i2c_stop();
    #(2*T);

    // Read back across the wrap
    i2c_start();
    send(8'hA0, 1'b0, "r1_addr_ack");
    send(8'h0F, 1'b0, "r1_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "r1_raddr_ack");
    recv(8'h11, 1'b0, "r1_reg15");
    recv(8'h22, 1'b1, "r1_reg0");
    i2c_stop();
    #(2*T);

    // Combined read from pointer 3, then NACK; SDA must stay released until STOP
    i2c_start();
    send(8'hA0, 1'b0, "r2_addr_ack");
    send(8'h03, 1'b0, "r2_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "r2_raddr_ack");
    recv(8'h5A, 1'b0, "r2_reg3");
    recv(8'h00, 1'b1, "r2_reg4");
    sda_viol  = 0;
    watch_rel = 1'b1;
    #(4*T);
    i2c_stop();
    #(T);
    watch_rel = 1'b0;
    check("r2_released_after_nack", 32'(sda_viol), 32'h0);
    #(2*T);

    // Address mismatch: no drive, no busy, no write
    wr_before  = n_wr;
    sda_viol   = 0;
    busy_viol  = 0;
    watch_rel  = 1'b1;
    watch_busy = 1'b1;
    i2c_start();
    send(8'hA2, 1'b1, "mm_addr_nack");
    send(8'hFF, 1'b1, "mm_data_nack");
    i2c_stop();
    #(2*T);
    watch_rel  = 1'b0;
    watch_busy = 1'b0;
    check("mm_sda_released", 32'(sda_viol), 32'h0);
    check("mm_busy_low", 32'(busy_viol), 32'h0);
    check("mm_no_write", 32'(n_wr), 32'(wr_before));

    // Reset while the target drives bit 3 (a 0) of reg 0 = 0x22
    i2c_start();
    send(8'hA0, 1'b0, "rr_addr_ack");
    send(8'h00, 1'b0, "rr_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "rr_raddr_ack");
    nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      read_bit(b);
      nib = {nib[2:0], b};
    end
    check("rr_high_nibble", 32'(nib), 32'h2);
    m_sda = 1'b1; #(T); m_scl = 1'b1; #(T);
    check("rr_bit3_driven_low", 32'(sda_o), 32'h0);
    rst = 1'b1;
    #1;
    check("rr_sda_released_on_rst", 32'(sda_o), 32'h1);
    check("rr_busy_on_rst", 32'(busy), 32'h0);
    #(T-1);
    rst = 1'b0;
    #(4*T);

    // Fresh transaction: registers were cleared
    i2c_start();
    send(8'hA0, 1'b0, "fr_addr_ack");
    send(8'h0F, 1'b0, "fr_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "fr_raddr_ack");
    recv(8'h00, 1'b0, "fr_reg15");
    recv(8'h00, 1'b1, "fr_reg0");
    i2c_stop();
    #(2*T);
    check("fr_busy_idle", 32'(busy), 32'h0);

    repeat (20) @(negedge clk);
    check("exp_queue_drained", 32'(exp_val_q.size()), 32'h0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
    check("total_writes", 32'(n_wr), 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
